imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart to the core's instruction fetch. The core only reads instruction memory.
- Accepts a framed byte stream over a valid/ready handshake: length byte, big-endian data words, XOR checksum byte.
- Assembles the bytes into 32-bit words and writes them into a 32-entry instruction memory.
- Provides the combinational fetch port the core reads; holds the core while a load is in progress.

Parameters:
DEPTH, 32, number of 32-bit instruction words
ADDR_W, 5, fetch/write word-address width (log2 DEPTH)

Ports:
clock_out  input  1  block clock (divided core clock)
reset  input  1  asynchronous, active-high
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
byte_in  input  8  stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte; transfer = byte_valid & byte_ready
fetch_addr  input  ADDR_W  word address from core PC bits [4:0]
fetch_data  output  32  mem[fetch_addr], combinational
core_hold  output  1  core must hold PC/reset while high
load_done  output  1  last load completed with good checksum
load_error  output  1  last load failed (bad length or checksum)
words_loaded  output  ADDR_W+1  words written in current/last load

Behaviour:
- Interface: reset is asynchronous, active-high; the block is clocked on clock_out.
- Reset values:
  - Outputs: byte_ready=0, core_hold=0, load_done=0, load_error=0, words_loaded=0.
  - Internal: state=IDLE, byte counter=0, write pointer=0, checksum accumulator=0.
  - Memory array is NOT reset; contents are preserved.
- All register updates occur on the rising edge of clock_out.
- States and transitions:
  - IDLE: byte_ready=0. start → LEN. In the same edge: core_hold←1, load_done←0, load_error←0, words_loaded←0, pointer←0, checksum←0.
  - LEN: byte_ready=1. On transfer, N=byte_in.
    - N==0 or N>DEPTH → ERROR.
    - Otherwise latch N → DATA.
  - DATA: byte_ready=1. Bytes arrive MSB first.
    - Each transfer: shift byte into the assembly register; checksum ^= byte_in; byte counter increments mod 4.
    - On the 4th byte of a word: mem[pointer] ← {assembled[23:0], byte_in} on that same edge; pointer++; words_loaded++.
    - When words_loaded reaches N on that edge → CSUM.
  - CSUM: byte_ready=1. On transfer:
    - byte_in == checksum → DONE: load_done←1, core_hold←0.
    - Mismatch → ERROR.
  - DONE: byte_ready=0. start → LEN, with the same initialisation as from IDLE.
  - ERROR: byte_ready=0, load_error=1, core_hold stays 1. start → LEN, with the same initialisation.
- Handshake rules:
  - byte_ready is a function of state only; no combinational dependence on byte_valid.
  - Cycles with byte_valid=0 change nothing.
  - byte_valid=1 in IDLE/DONE/ERROR is ignored; the byte is not consumed.
- Simultaneous events:
  - start while in LEN/DATA/CSUM is ignored.
  - start together with byte_valid in IDLE: only start acts; the byte is not consumed.
- Write/read ordering:
  - A word written on edge k is visible on fetch_data after edge k.
  - fetch_data never returns a partially assembled word.
- Capacity:
  - The pointer never exceeds N-1; no write wraps to address 0 within a load.
  - Entries at addresses ≥N keep prior contents.
- Length/checksum scope: the checksum covers data bytes only. The length byte and checksum byte are excluded.
- Reset mid-load: immediate return to IDLE.
  - core_hold=0, words_loaded=0, partial assembly discarded.
  - Words already written remain in memory.

Test Plan:
1. start; stream 02, 20,01,00,03, 20,02,00,03, checksum 03 → load_done=1, core_hold=0, words_loaded=2; fetch_addr=0 → 0x20010003, fetch_addr=1 → 0x20020003.
2. Same stream with checksum 04 → load_error=1, load_done=0, core_hold=1, byte_ready=0; a second start with the correct stream → load_done=1, load_error=0.
3. Length byte 00, and separately length 0x21 (33) → ERROR on the edge after the length transfer; no memory write; words_loaded=0.
4. Case 1 stream with byte_valid deasserted for 3 random cycles between every byte, plus byte_valid=1 while in IDLE before start → identical final memory and flags; the pre-start byte is not consumed.
5. Assert reset after 6 data bytes of case 1 → core_hold=0, words_loaded=0, state IDLE; word 0 = 0x20010003 retained; a subsequent full N=1 load of 0xDEADBEEF (checksum 0x22) → mem[0]=0xDEADBEEF, load_done=1.
6. N=32 with word i = i → words_loaded=32, mem[31]=0x0000001F, mem[0]=0x00000000 unchanged after CSUM (no wrap write); checksum 0x00 → load_done=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream load channel between a stream source and the instruction-memory loader.
interface imem_loader_if;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output start,
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  start,
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte stream (length, big-endian words,
// XOR checksum), writes the words into a small instruction memory and exposes a
// combinational fetch port to the core, holding the core while a load is running.
module imem_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock_out,
    input  logic              reset,
    imem_loader_if.slave      bus,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_data,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StDone, StError} state_e;

    localparam logic [8:0]        DepthB   = 9'(DEPTH);
    localparam logic [ADDR_W-1:0] AddrOne  = 1;
    localparam logic [ADDR_W:0]   WordsOne = 1;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [7:0]          csum_q, csum_d;
    logic [23:0]         asm_q, asm_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic                xfer;
    logic [31:0]         mem_q [DEPTH];

    // Ready depends on state alone so the source never sees a combinational loop.
    assign bus.byte_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign xfer           = bus.byte_valid && bus.byte_ready;

    assign fetch_data   = mem_q[fetch_addr];
    assign core_hold    = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;

    // Next-state and datapath decisions for the load FSM.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        asm_d   = asm_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StIdle, StDone, StError: begin
                // Stream bytes are ignored here; only start acts.
                if (bus.start) begin
                    state_d = StLen;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
            end
            StLen: begin
                if (xfer) begin
                    if (bus.byte_in == 8'd0 || {1'b0, bus.byte_in} > DepthB) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end else begin
                        len_d   = bus.byte_in[ADDR_W:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    asm_d  = {asm_q[15:0], bus.byte_in};
                    csum_d = csum_q ^ bus.byte_in;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        mem_we  = 1'b1;
                        words_d = words_q + WordsOne;
                        // Pointer stays on the last word so it never wraps past N-1.
                        if (words_d == len_q) begin
                            state_d = StCsum;
                        end else begin
                            ptr_d = ptr_q + AddrOne;
                        end
                    end
                end
            end
            StCsum: begin
                if (xfer) begin
                    if (bus.byte_in == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and datapath registers; reset discards any partial assembly.
    always_ff @(posedge clock_out or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            words_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            asm_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            asm_q   <= asm_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Instruction store; not reset so words survive a reset mid-load.
    always_ff @(posedge clock_out) begin
        if (mem_we) begin
            mem_q[ptr_q] <= {asm_q, bus.byte_in};
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        clock_out;
    logic        reset;
    logic [4:0]  fetch_addr;
    logic [31:0] fetch_data;
    logic        core_hold;
    logic        load_done;
    logic        load_error;
    logic [5:0]  words_loaded;

    int checks;
    int failures;

    logic [7:0] frame[$];

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH  (32),
        .ADDR_W (5)
    ) dut (
        .clock_out    (clock_out),
        .reset        (reset),
        .bus          (bus.slave),
        .fetch_addr   (fetch_addr),
        .fetch_data   (fetch_data),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clock_out = 1'b0;
    always #5 clock_out = ~clock_out;

    task automatic tick();
        @(posedge clock_out);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Present one byte and hold it until it is taken on a clock edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout: byte_ready=%b required=1", bus.byte_ready);
        end
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap);
        foreach (frame[i]) begin
            repeat (gap) tick();
            send_byte(frame[i]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus.byte_ready, core_hold, load_done, load_error, words_loaded} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b hold=%b done=%b err=%b words=%0d required all 0",
                     bus.byte_ready, core_hold, load_done, load_error, words_loaded);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_good_load();
        pulse_start();
        checks++;
        if (core_hold !== 1'b1 || bus.byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_to_len: hold=%b rdy=%b required 1 1", core_hold, bus.byte_ready);
        end
        frame = {8'h02, 8'h20, 8'h01, 8'h00, 8'h03, 8'h20, 8'h02, 8'h00, 8'h03, 8'h03};
        send_frame(0);
        checks++;
        if (load_done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 6'd2 ||
            bus.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL good_flags: done=%b hold=%b words=%0d rdy=%b required 1 0 2 0",
                     load_done, core_hold, words_loaded, bus.byte_ready);
        end
        fetch_addr = 5'd0; #1;
        checks++;
        if (fetch_data !== 32'h2001_0003) begin
            failures++;
            $display("FAIL good_word0: got %h required 20010003", fetch_data);
        end
        fetch_addr = 5'd1; #1;
        checks++;
        if (fetch_data !== 32'h2002_0003) begin
            failures++;
            $display("FAIL good_word1: got %h required 20020003", fetch_data);
        end
    endtask

    task automatic test_bad_csum();
        pulse_start();
        frame = {8'h02, 8'h20, 8'h01, 8'h00, 8'h03, 8'h20, 8'h02, 8'h00, 8'h03, 8'h04};
        send_frame(0);
        checks++;
        if (load_error !== 1'b1 || load_done !== 1'b0 || core_hold !== 1'b1 ||
            bus.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL bad_csum_flags: err=%b done=%b hold=%b rdy=%b required 1 0 1 0",
                     load_error, load_done, core_hold, bus.byte_ready);
        end
        pulse_start();
        checks++;
        if (load_error !== 1'b0 || words_loaded !== 6'd0) begin
            failures++;
            $display("FAIL restart_clear: err=%b words=%0d required 0 0", load_error, words_loaded);
        end
        frame[9] = 8'h03;
        send_frame(0);
        checks++;
        if (load_done !== 1'b1 || load_error !== 1'b0) begin
            failures++;
            $display("FAIL retry_flags: done=%b err=%b required 1 0", load_done, load_error);
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens [2];
        lens[0] = 8'h00;
        lens[1] = 8'h21;
        for (int i = 0; i < 2; i++) begin
            pulse_start();
            send_byte(lens[i]);
            checks++;
            if (load_error !== 1'b1 || words_loaded !== 6'd0 || bus.byte_ready !== 1'b0) begin
                failures++;
                $display("FAIL bad_len_%h: err=%b words=%0d rdy=%b required 1 0 0",
                         lens[i], load_error, words_loaded, bus.byte_ready);
            end
            fetch_addr = 5'd0; #1;
            checks++;
            if (fetch_data !== 32'h2001_0003) begin
                failures++;
                $display("FAIL bad_len_mem_%h: got %h required 20010003", lens[i], fetch_data);
            end
        end
    endtask

    task automatic test_stalls();
        // Overwrite words 0/1 so the stalled reload is observable.
        pulse_start();
        frame = {8'h02, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h00};
        send_frame(0);
        fetch_addr = 5'd0; #1;
        checks++;
        if (fetch_data !== 32'h1111_1111) begin
            failures++;
            $display("FAIL stall_preload: got %h required 11111111", fetch_data);
        end
        reset = 1'b1; #2; reset = 1'b0;
        tick();
        // A byte offered in IDLE must not be consumed.
        bus.byte_in    = 8'h05;
        bus.byte_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.byte_ready !== 1'b0 || core_hold !== 1'b0) begin
            failures++;
            $display("FAIL idle_byte: rdy=%b hold=%b required 0 0", bus.byte_ready, core_hold);
        end
        pulse_start();
        bus.byte_valid = 1'b0;
        frame = {8'h02, 8'h20, 8'h01, 8'h00, 8'h03, 8'h20, 8'h02, 8'h00, 8'h03, 8'h03};
        send_frame(3);
        checks++;
        if (load_done !== 1'b1 || load_error !== 1'b0 || words_loaded !== 6'd2) begin
            failures++;
            $display("FAIL stall_flags: done=%b err=%b words=%0d required 1 0 2",
                     load_done, load_error, words_loaded);
        end
        fetch_addr = 5'd1; #1;
        checks++;
        if (fetch_data !== 32'h2002_0003) begin
            failures++;
            $display("FAIL stall_word1: got %h required 20020003", fetch_data);
        end
    endtask

    task automatic test_full_depth();
        pulse_start();
        frame = {8'h20};
        for (int i = 0; i < 32; i++) begin
            frame.push_back(8'h00);
            frame.push_back(8'h00);
            frame.push_back(8'h00);
            frame.push_back(8'(i));
        end
        send_frame(0);
        checks++;
        if (words_loaded !== 6'd32 || bus.byte_ready !== 1'b1 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL full_pre_csum: words=%0d rdy=%b done=%b required 32 1 0",
                     words_loaded, bus.byte_ready, load_done);
        end
        send_byte(8'h00);
        checks++;
        if (load_done !== 1'b1 || words_loaded !== 6'd32) begin
            failures++;
            $display("FAIL full_done: done=%b words=%0d required 1 32", load_done, words_loaded);
        end
        fetch_addr = 5'd31; #1;
        checks++;
        if (fetch_data !== 32'h0000_001F) begin
            failures++;
            $display("FAIL full_word31: got %h required 0000001f", fetch_data);
        end
        fetch_addr = 5'd0; #1;
        checks++;
        if (fetch_data !== 32'h0000_0000) begin
            failures++;
            $display("FAIL full_word0: got %h required 00000000", fetch_data);
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        frame = {8'h02, 8'h20, 8'h01, 8'h00, 8'h03, 8'h20, 8'h02};
        send_frame(0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (core_hold !== 1'b0 || words_loaded !== 6'd0 || bus.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: hold=%b words=%0d rdy=%b required 0 0 0",
                     core_hold, words_loaded, bus.byte_ready);
        end
        reset = 1'b0;
        tick();
        fetch_addr = 5'd0; #1;
        checks++;
        if (fetch_data !== 32'h2001_0003) begin
            failures++;
            $display("FAIL mid_reset_word0: got %h required 20010003", fetch_data);
        end
        fetch_addr = 5'd1; #1;
        checks++;
        if (fetch_data !== 32'h0000_0001) begin
            failures++;
            $display("FAIL mid_reset_word1: got %h required 00000001", fetch_data);
        end
        pulse_start();
        frame = {8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_frame(0);
        fetch_addr = 5'd0; #1;
        checks++;
        if (fetch_data !== 32'hDEAD_BEEF || load_done !== 1'b1 || words_loaded !== 6'd1) begin
            failures++;
            $display("FAIL after_reset_load: word0=%h done=%b words=%0d required deadbeef 1 1",
                     fetch_data, load_done, words_loaded);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        fetch_addr     = 5'd0;
        #1;
        test_reset();
        test_good_load();
        test_bad_csum();
        test_bad_len();
        test_stalls();
        test_full_depth();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
